// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - shared sizes, index type and arbiter state encoding for the RS issue path
package rs_pkg;

  localparam int RS_BITS = 4;
  localparam int RS_SIZE = 1 << RS_BITS;

  typedef logic [RS_BITS-1:0] rs_idx_t;

  localparam logic [0:0] ARB_EMPTY = 1'b0;
  localparam logic [0:0] ARB_HOLD  = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating priority encoder: first set bit of req & ~mask scanning upward from ptr
module rr_pick #(
  parameter int BITS = 4,
  parameter int SIZE = 16
) (
  input  logic [SIZE-1:0] req,
  input  logic [SIZE-1:0] mask,
  input  logic [BITS-1:0] ptr,
  output logic            found,
  output logic [BITS-1:0] idx
);

  logic [SIZE-1:0] cand;

  assign cand = req & ~mask;

  // The index adder is BITS wide, so ptr + i wraps past SIZE-1 back to 0.
  always_comb begin
    logic [BITS-1:0] pos;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int i = 0; i < SIZE; i++) begin
      pos = ptr + BITS'(i);
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/rs_issue_arbiter.sv
// rtl/rs_issue_arbiter.sv - round-robin RS issue arbiter with registered valid/ready to the ALU; RS_ARB_PERF_CNT_EN adds issue/stall counters
module rs_issue_arbiter
  import rs_pkg::*;
#(
  parameter int BITS = RS_BITS,
  parameter int SIZE = RS_SIZE
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            flush_in,
  input  logic [SIZE-1:0] req_vec,
  input  logic            alu_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_idx,
`ifdef RS_ARB_PERF_CNT_EN
  output logic            fire,
  output logic [31:0]     perf_issue_cnt,
  output logic [31:0]     perf_stall_cnt
`else
  output logic            fire
`endif
);

  logic [0:0]      state;
  logic [BITS-1:0] ptr;
  logic [SIZE-1:0] held_mask;
  logic            pick_found;
  logic [BITS-1:0] pick_idx;

  assign out_valid = (state == ARB_HOLD);

  // The held entry stays busy in req_vec until the RS sees fire, so it must not win again.
  assign held_mask = out_valid ? (SIZE'(1) << out_idx) : '0;

  assign fire = out_valid && alu_ready && rdy_in && rst_in && !flush_in;

  rr_pick #(
    .BITS (BITS),
    .SIZE (SIZE)
  ) u_pick (
    .req   (req_vec),
    .mask  (held_mask),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state   <= ARB_EMPTY;
      out_idx <= '0;
      ptr     <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        state <= ARB_EMPTY;
        ptr   <= '0;
      end else if (state == ARB_EMPTY || alu_ready) begin
        if (pick_found) begin
          state   <= ARB_HOLD;
          out_idx <= pick_idx;
          ptr     <= pick_idx + BITS'(1);
        end else begin
          state <= ARB_EMPTY;
        end
      end
    end
  end

`ifdef RS_ARB_PERF_CNT_EN
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (rdy_in) begin
      if (fire) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end
      if (out_valid && !alu_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
